// File: rtl/div_host_sequencer.sv
// Host-side sequencer for the repeated-subtraction divider.
// Launches one divide per request and returns quotient plus error flags.
module div_host_sequencer #(
  parameter int WIDTH       = 8,
  parameter int START_WAIT  = 4,
  parameter int RUN_TIMEOUT = 2048,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quot,
  output logic [1:0]       rsp_err,
  output logic             proc_start,
  output logic [WIDTH-1:0] proc_a,
  output logic [WIDTH-1:0] proc_b,
  input  logic             proc_busy,
  input  logic [WIDTH-1:0] proc_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RUN,
    S_SETTLE,
    S_RESP
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [1:0]       err_q, err_d;
  logic             req_fire;

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign proc_start = (state_q == S_LAUNCH);
  assign proc_a     = a_q;
  assign proc_b     = b_q;
  assign rsp_quot   = quot_q;
  assign rsp_err    = err_q;
  assign req_fire   = req_valid && req_ready;
  assign cnt_inc    = cnt_q + CNT_W'(1);

  // Next-state, watchdog and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    quot_d  = quot_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          a_d = req_a;
          b_d = req_b;
          if (req_b == '0) begin
            quot_d  = '0;
            err_d   = ERR_DIV0;
            state_d = S_RESP;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (proc_busy) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(START_WAIT)) begin
            quot_d  = '0;
            err_d   = ERR_TOUT;
            state_d = S_RESP;
          end
        end
      end
      S_RUN: begin
        if (!proc_busy) begin
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(RUN_TIMEOUT)) begin
            quot_d  = '0;
            err_d   = ERR_TOUT;
            state_d = S_RESP;
          end
        end
      end
      S_SETTLE: begin
        quot_d  = proc_out;
        err_d   = ERR_NONE;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_div_host_sequencer.sv
// Directed bench for div_host_sequencer with a behavioural divider model.
// Model modes: 0 = full-length divide, 1 = never busy, 2 = one-cycle Busy.
module tb_div_host_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a, req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_quot;
  logic [1:0] rsp_err;
  logic       proc_start;
  logic [7:0] proc_a, proc_b;
  logic       proc_busy;
  logic [7:0] proc_out;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;
  int mcnt  = 0;
  logic [7:0] mq;
  int starts   = 0;
  int unstable = 0;
  logic       prev_rdy = 1'b1;
  logic [7:0] prev_a, prev_b;
  int cyc;

  always #5 clk = ~clk;

  div_host_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_quot   (rsp_quot),
    .rsp_err    (rsp_err),
    .proc_start (proc_start),
    .proc_a     (proc_a),
    .proc_b     (proc_b),
    .proc_busy  (proc_busy),
    .proc_out   (proc_out)
  );

  function automatic logic [7:0] qdiv(input logic [7:0] a, input logic [7:0] b);
    int r, q;
    r = a;
    q = 0;
    if (b == 0) return 8'd0;
    while (r >= b) begin
      r = r - b;
      q++;
    end
    return q[7:0];
  endfunction

  // Divider model: Busy rises the edge after Start, reg0 updates as Busy falls
  always @(posedge clk) begin
    if (reset) begin
      proc_busy <= 1'b0;
      mcnt      <= 0;
    end else if (!proc_busy && proc_start) begin
      if (mode == 0) begin
        proc_busy <= 1'b1;
        mcnt      <= 6 * int'(qdiv(proc_a, proc_b)) + 10;
        mq        <= qdiv(proc_a, proc_b);
      end else if (mode == 2) begin
        proc_busy <= 1'b1;
        mcnt      <= 1;
        mq        <= qdiv(proc_a, proc_b);
      end
    end else if (proc_busy) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        proc_busy <= 1'b0;
        proc_out  <= mq;
      end
    end
  end

  // Start pulse counter and operand stability monitor
  always @(negedge clk) begin
    if (proc_start) starts <= starts + 1;
    if (!req_ready && !prev_rdy && (proc_a != prev_a || proc_b != prev_b))
      unstable <= unstable + 1;
    prev_rdy <= req_ready;
    prev_a   <= proc_a;
    prev_b   <= proc_b;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    check("req_ready_at_send", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_within_budget", int'(rsp_valid), 1);
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", int'(rsp_valid), 0);
    check("req_ready_after_hs", int'(req_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    proc_out  = 8'hAA;
    repeat (2) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_proc_start", int'(proc_start), 0);
    check("rst_proc_a", int'(proc_a), 0);
    check("rst_proc_b", int'(proc_b), 0);
    check("rst_rsp_quot", int'(rsp_quot), 0);
    check("rst_rsp_err", int'(rsp_err), 0);
    reset = 1'b0;
    @(negedge clk);

    // 100/7 with a single-cycle Busy pulse
    mode   = 2;
    starts = 0;
    send(8'd100, 8'd7);
    check("t1_a", int'(proc_a), 100);
    check("t1_b", int'(proc_b), 7);
    wait_rsp(cyc);
    check("t1_latency", cyc, 4);
    check("t1_quot", int'(rsp_quot), 14);
    check("t1_err", int'(rsp_err), 0);
    check("t1_starts", starts, 1);
    check("t1_stable", unstable, 0);
    finish_rsp();

    // 5/0: divider never launched
    starts = 0;
    send(8'd5, 8'd0);
    check("t2_valid_next", int'(rsp_valid), 1);
    check("t2_quot", int'(rsp_quot), 0);
    check("t2_err", int'(rsp_err), 1);
    finish_rsp();
    check("t2_starts", starts, 0);

    // 255/1: longest divide must not time out
    mode = 0;
    send(8'd255, 8'd1);
    wait_rsp(cyc);
    check("t3_quot", int'(rsp_quot), 255);
    check("t3_err", int'(rsp_err), 0);
    check("t3_stable", unstable, 0);
    finish_rsp();

    // Busy never rises: start timeout
    mode = 1;
    send(8'd9, 8'd3);
    wait_rsp(cyc);
    check("t4_latency", cyc, 5);
    check("t4_quot", int'(rsp_quot), 0);
    check("t4_err", int'(rsp_err), 2);
    finish_rsp();

    // Reset in the middle of RUN
    mode = 0;
    send(8'd100, 8'd7);
    repeat (20) @(negedge clk);
    check("t5_busy_pre", int'(proc_busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_req_ready", int'(req_ready), 1);
    check("t5_rsp_valid", int'(rsp_valid), 0);
    check("t5_proc_start", int'(proc_start), 0);
    reset = 1'b0;
    @(negedge clk);
    send(8'd9, 8'd3);
    wait_rsp(cyc);
    check("t5_quot", int'(rsp_quot), 3);
    check("t5_err", int'(rsp_err), 0);
    finish_rsp();

    // 3/5 with back-pressure; a competing request must not be taken
    send(8'd3, 8'd5);
    wait_rsp(cyc);
    req_valid = 1'b1;
    req_a     = 8'd1;
    req_b     = 8'd1;
    for (int i = 0; i < 10; i++) begin
      check("t6_valid_hold", int'(rsp_valid), 1);
      check("t6_quot_hold", int'(rsp_quot), 0);
      check("t6_err_hold", int'(rsp_err), 0);
      check("t6_req_ready", int'(req_ready), 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    finish_rsp();
    @(negedge clk);
    check("t6_no_extra_rsp", int'(rsp_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_host_sequencer.md
Name: div_host_sequencer

Overview:
- Initiator-side controller for the repeated-subtraction divider datapath.
- Accepts dividend/divisor pairs over a valid/ready request channel and drives the divider's Start, inA and inB.
- Tracks the divider's Busy pulse, captures the quotient from the divider output register, and returns it with error flags over a valid/ready response channel.
- Sits between the system bus or test harness and the divider processor top.

Parameters:
- WIDTH, 8: operand and quotient width; must match the divider datapath.
- START_WAIT, 4: maximum cycles from proc_start to proc_busy rising before a start timeout.
- RUN_TIMEOUT, 2048: maximum cycles with proc_busy high before a run timeout. Must exceed the worst-case divide, which is 255/1 at about 1540 cycles.
- CNT_W, 12: watchdog counter width; must satisfy 2^CNT_W > RUN_TIMEOUT.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request operands valid.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  WIDTH  dividend.
- req_b  in  WIDTH  divisor.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_quot  out  WIDTH  quotient; 0 on any error.
- rsp_err  out  2  bit0 = divide-by-zero, bit1 = timeout.
- proc_start  out  1  Start to the divider.
- proc_a  out  WIDTH  divider inA.
- proc_b  out  WIDTH  divider inB.
- proc_busy  in  1  divider Busy.
- proc_out  in  WIDTH  divider output register (reg0).

Behaviour:
- Reset values on the clock edge where reset=1:
  - State is IDLE.
  - req_ready=1, rsp_valid=0, proc_start=0.
  - proc_a, proc_b, rsp_quot, rsp_err and the counter are all 0.
- Reset takes priority over all other inputs. A reset in any state, including RUN, drops proc_start and abandons the transaction with no response.
- Request handshake: a transfer occurs on a cycle where req_valid=1 and req_ready=1. req_ready=1 only in IDLE.
- Operands are registered into proc_a/proc_b on acceptance. They are held constant until the state returns to IDLE, because the divider re-reads inB on every iteration.
- States:
  - IDLE: on request transfer:
    - If req_b==0, go to RESP with rsp_quot=0 and rsp_err=01. The divider is not launched.
    - Otherwise go to LAUNCH.
  - LAUNCH: proc_start=1 for exactly this one cycle. Clear the counter and go to WAIT_BUSY.
  - WAIT_BUSY: proc_start=0.
    - If proc_busy=1, clear the counter and go to RUN.
    - Otherwise increment the counter. When it reaches START_WAIT, go to RESP with rsp_quot=0 and rsp_err=10.
  - RUN:
    - If proc_busy=0, go to SETTLE.
    - Otherwise increment the counter. When it reaches RUN_TIMEOUT, go to RESP with rsp_quot=0 and rsp_err=10.
  - SETTLE: one cycle, covering the divider writing reg0 in the same state that drops Busy. Capture proc_out into rsp_quot, set rsp_err=00, and go to RESP.
  - RESP: rsp_valid=1.
    - rsp_quot and rsp_err are held stable while rsp_ready=0.
    - On rsp_ready=1, go to IDLE; rsp_valid=0 the next cycle.
- Latency:
  - Normal path: response valid 3 cycles after Busy falls is not the rule; rsp_valid rises 2 cycles after the first cycle with proc_busy=0 in RUN.
  - Divide-by-zero path: rsp_valid rises 1 cycle after acceptance.
- No new request is accepted while a response is pending; there is no overlap.
- A single-cycle Busy pulse is legal: it is seen in WAIT_BUSY, and then RUN exits on the next low cycle.
- Busy already high in LAUNCH is ignored; Busy is only sampled from WAIT_BUSY onward.

Test Plan:
- a=100, b=7, divider model returns 14 after a Busy pulse → one proc_start pulse, proc_a/proc_b stable throughout, rsp_quot=14, rsp_err=00.
- a=5, b=0 → proc_start never asserted; rsp_valid rises the cycle after acceptance with rsp_quot=0, rsp_err=01.
- a=255, b=1 with the real divider → rsp_quot=255, rsp_err=00, no timeout at about 1540 Busy cycles.
- proc_busy tied 0, b=3 → rsp_err=10 and rsp_quot=0 exactly START_WAIT cycles into WAIT_BUSY; req_ready=1 after rsp_ready.
- Reset asserted mid-RUN with proc_busy=1 → next cycle state is IDLE, proc_start=0, rsp_valid=0, req_ready=1. A following request 9/3 returns 3.
- a=3, b=5 with rsp_ready held 0 for 10 cycles → rsp_valid=1 with rsp_quot=0 stable; req_ready stays 0 until the handshake completes.
